// File: rtl/uart_tx_queue.sv
// uart_tx_queue
// Multi-producer UART transmit path. NUM_SRC producers offer bytes over a
// valid/ready handshake. A round-robin arbiter accepts at most one byte per
// clock into a DEPTH-entry FIFO. A serializer drains the FIFO onto the tx line
// with a configurable baud divider, parity and stop-bit count.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   src_valid   per-source byte valid, held until accepted
//   src_data    byte of source i in bits [8i+7:8i]
//   src_ready   one-hot grant; transfer when valid and ready are both high
//   tx          UART serial line, idle high, registered
//   busy        high while a frame is on the line
//   fifo_level  current FIFO occupancy
//   fifo_full   FIFO occupancy equals DEPTH
module uart_tx_queue #(
   parameter int NUM_SRC     = 2,
   parameter int DEPTH       = 16,
   parameter int BAUD_DIV    = 10416,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_SRC-1:0]       src_valid,
   input  logic [8*NUM_SRC-1:0]     src_data,
   output logic [NUM_SRC-1:0]       src_ready,
   output logic                     tx,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     fifo_full
);

   localparam int PW        = $clog2(DEPTH);
   localparam int LW        = PW + 1;
   localparam int SW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int STOP_CLKS = STOP_BITS * BAUD_DIV;
   localparam int CW        = $clog2(STOP_CLKS + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

   logic [SW-1:0] lastGrant_q, lastGrant_d;
   logic [SW-1:0] grantIdx, cand;
   logic          grantFound, canGrant, push, pop, fifoFull, bitEnd;
   logic [7:0]    wrData, popData;

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [LW-1:0] level_q, level_d;

   state_e        state_q, state_d;
   logic [CW-1:0] baudCnt_q, baudCnt_d;
   logic [2:0]    bitCnt_q, bitCnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic          tx_q, tx_d, busy_q, busy_d;

   // Round-robin search starting one past the last granted source, wrapping.
   always_comb begin
      grantIdx   = '0;
      grantFound = 1'b0;
      cand       = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand = SW'((int'(lastGrant_q) + k) % NUM_SRC);
         if (!grantFound && src_valid[cand]) begin
            grantFound = 1'b1;
            grantIdx   = cand;
         end
      end
   end

   // Grants are suppressed while full and while reset is held, so nothing can
   // be handed over while the queue is being cleared.
   assign fifoFull  = (level_q == LW'(DEPTH));
   assign canGrant  = grantFound && !fifoFull && rst_n;
   assign src_ready = canGrant ? (NUM_SRC'(1) << grantIdx) : '0;
   assign push      = canGrant;
   assign wrData    = src_data[8*int'(grantIdx) +: 8];
   assign popData   = mem_q[rdPtr_q];

   // FIFO storage needs no reset; only pointers and level define its contents.
   always_ff @(posedge clk) begin
      if (push) mem_q[wrPtr_q] <= wrData;
   end

   // Pointer, level and arbiter bookkeeping; pointers wrap naturally at DEPTH.
   always_comb begin
      wrPtr_d     = push ? wrPtr_q + 1'b1 : wrPtr_q;
      rdPtr_d     = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
      lastGrant_d = push ? grantIdx : lastGrant_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Every state lasts one bit time except STOP, which lasts STOP_BITS of them.
   assign bitEnd = (state_q == STOP) ? (baudCnt_q == CW'(STOP_CLKS - 1))
                                     : (baudCnt_q == CW'(BAUD_DIV - 1));

   // Serializer next-state logic. A frame may load straight out of STOP so that
   // queued bytes go out back-to-back without an idle cycle.
   always_comb begin
      state_d   = state_q;
      baudCnt_d = baudCnt_q + 1'b1;
      bitCnt_d  = bitCnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            baudCnt_d = '0;
            if (level_q != '0) begin
               pop      = 1'b1;
               state_d  = START;
               shift_d  = popData;
               parity_d = (^popData) ^ (PARITY_MODE == 2);
            end
         end
         START: begin
            if (bitEnd) begin
               state_d   = DATA;
               bitCnt_d  = '0;
               baudCnt_d = '0;
            end
         end
         DATA: begin
            if (bitEnd) begin
               baudCnt_d = '0;
               if (bitCnt_q == 3'd7) begin
                  state_d = (PARITY_MODE != 0) ? PARITY : STOP;
               end else begin
                  bitCnt_d = bitCnt_q + 1'b1;
                  shift_d  = shift_q >> 1;
               end
            end
         end
         PARITY: begin
            if (bitEnd) begin
               state_d   = STOP;
               baudCnt_d = '0;
            end
         end
         STOP: begin
            if (bitEnd) begin
               baudCnt_d = '0;
               if (level_q != '0) begin
                  pop      = 1'b1;
                  state_d  = START;
                  shift_d  = popData;
                  parity_d = (^popData) ^ (PARITY_MODE == 2);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level and busy are decoded from the next state and then registered,
   // so tx never glitches and busy drops on the same edge tx goes idle.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = 1'b1;
      case (state_d)
         IDLE:    busy_d = 1'b0;
         START:   tx_d   = 1'b0;
         DATA:    tx_d   = shift_d[0];
         PARITY:  tx_d   = parity_d;
         STOP:    tx_d   = 1'b1;
         default: busy_d = 1'b0;
      endcase
   end

   // All state registers; reset truncates any frame and discards the queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lastGrant_q <= SW'(NUM_SRC - 1);
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         level_q     <= '0;
         state_q     <= IDLE;
         baudCnt_q   <= '0;
         bitCnt_q    <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         lastGrant_q <= lastGrant_d;
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         level_q     <= level_d;
         state_q     <= state_d;
         baudCnt_q   <= baudCnt_d;
         bitCnt_q    <= bitCnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign fifo_level = level_q;
   assign fifo_full  = fifoFull;

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue
// Drives three differently configured queues (no parity / even parity / odd
// parity with two stop bits) from held-until-accepted random producers and
// compares every cycle against a frame-level reference model: a byte queue per
// instance, a round-robin pointer, and the current frame as a list of bit
// levels indexed by elapsed clocks.
module tb_uart_tx_queue;

   localparam int NS = 3;
   localparam int DP = 4;
   localparam int LW = 3;

   function automatic int bdOf(input int u);
      case (u)
         0:       return 4;
         1:       return 3;
         default: return 5;
      endcase
   endfunction

   function automatic int pmOf(input int u);
      case (u)
         0:       return 0;
         1:       return 1;
         default: return 2;
      endcase
   endfunction

   function automatic int sbOf(input int u);
      return (u == 2) ? 2 : 1;
   endfunction

   logic clk;
   logic rst_n;

   logic [NS-1:0]   srcValid [3];
   logic [8*NS-1:0] srcData  [3];
   logic [NS-1:0]   srcReady [3];
   logic            txLine   [3];
   logic            busyLine [3];
   logic [LW-1:0]   levelOut [3];
   logic            fullOut  [3];

   for (genvar g = 0; g < 3; g++) begin : gDut
      uart_tx_queue #(
         .NUM_SRC     (NS),
         .DEPTH       (DP),
         .BAUD_DIV    (bdOf(g)),
         .PARITY_MODE (pmOf(g)),
         .STOP_BITS   (sbOf(g))
      ) dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .src_valid  (srcValid[g]),
         .src_data   (srcData[g]),
         .src_ready  (srcReady[g]),
         .tx         (txLine[g]),
         .busy       (busyLine[g]),
         .fifo_level (levelOut[g]),
         .fifo_full  (fullOut[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Producer state: a pending byte stays offered until the model grants it.
   bit         pend [3][NS];
   logic [7:0] pdat [3][NS];

   // Reference model state.
   logic [7:0]  q0[$];
   logic [7:0]  q1[$];
   logic [7:0]  q2[$];
   int          lastG   [3];
   bit          mActive [3];
   int          mT      [3];
   int          mLen    [3];
   logic [11:0] mBits   [3];

   function automatic int qSize(input int u);
      case (u)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic qPush(input int u, input logic [7:0] b);
      case (u)
         0:       q0.push_back(b);
         1:       q1.push_back(b);
         default: q2.push_back(b);
      endcase
   endtask

   function automatic logic [7:0] qPop(input int u);
      case (u)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   task automatic checkOutput(input string tag, input int u,
                              input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s inst%0d observed=%0h expected=%0h", tag, u, obs, exp);
      end
   endtask

   task automatic modelReset();
      q0.delete();
      q1.delete();
      q2.delete();
      for (int u = 0; u < 3; u++) begin
         lastG[u]   = NS - 1;
         mActive[u] = 1'b0;
         mT[u]      = 0;
         mLen[u]    = 0;
         mBits[u]   = '1;
      end
   endtask

   task automatic driveInputs();
      for (int u = 0; u < 3; u++)
         for (int s = 0; s < NS; s++) begin
            srcValid[u][s]       = pend[u][s];
            srcData[u][8*s +: 8] = pdat[u][s];
         end
   endtask

   // Frame as line levels per bit time: start, 8 data LSB first, parity, stops.
   task automatic startFrame(input int u, input logic [7:0] b);
      logic [11:0] v;
      int nBits;
      v     = '1;
      v[0]  = 1'b0;
      v[8:1] = b;
      nBits = 10 + sbOf(u) - 1;
      if (pmOf(u) != 0) begin
         v[9]  = (^b) ^ (pmOf(u) == 2);
         nBits = nBits + 1;
      end
      mBits[u]   = v;
      mLen[u]    = nBits * bdOf(u);
      mT[u]      = 0;
      mActive[u] = 1'b1;
   endtask

   task automatic checkResetState();
      for (int u = 0; u < 3; u++) begin
         checkOutput("rstTx",    u, txLine[u],   1);
         checkOutput("rstBusy",  u, busyLine[u], 0);
         checkOutput("rstLevel", u, levelOut[u], 0);
         checkOutput("rstFull",  u, fullOut[u],  0);
         checkOutput("rstReady", u, srcReady[u], 0);
      end
   endtask

   // One clock: check outputs at the falling edge, offer new bytes, check the
   // grant, then advance the model across the coming rising edge.
   task automatic applyStimulus(input int rate);
      int g;
      logic [7:0] b;
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         checkOutput("tx",    u, txLine[u],   mActive[u] ? mBits[u][mT[u] / bdOf(u)] : 1'b1);
         checkOutput("busy",  u, busyLine[u], mActive[u]);
         checkOutput("level", u, levelOut[u], qSize(u));
         checkOutput("full",  u, fullOut[u],  qSize(u) == DP);
      end
      for (int u = 0; u < 3; u++)
         for (int s = 0; s < NS; s++)
            if (rate > 0 && !pend[u][s] && $urandom_range(rate - 1, 0) == 0) begin
               pend[u][s] = 1'b1;
               pdat[u][s] = 8'($urandom);
            end
      driveInputs();
      #1;
      for (int u = 0; u < 3; u++) begin
         g = -1;
         if (qSize(u) < DP)
            for (int k = 1; k <= NS; k++)
               if (g < 0 && pend[u][(lastG[u] + k) % NS]) g = (lastG[u] + k) % NS;
         checkOutput("ready", u, srcReady[u], (g < 0) ? 0 : (1 << g));
         if (mActive[u]) begin
            mT[u]++;
            if (mT[u] == mLen[u]) mActive[u] = 1'b0;
         end
         if (!mActive[u] && qSize(u) > 0) begin
            b = qPop(u);
            startFrame(u, b);
         end
         if (g >= 0) begin
            qPush(u, pdat[u][g]);
            pend[u][g] = 1'b0;
            lastG[u]   = g;
         end
      end
   endtask

   initial begin
      bit found;
      rst_n = 1'b0;
      for (int u = 0; u < 3; u++)
         for (int s = 0; s < NS; s++) begin
            pend[u][s] = 1'b0;
            pdat[u][s] = 8'h00;
         end
      // Bytes offered during reset must not be granted until release.
      pend[0][0] = 1'b1; pdat[0][0] = 8'hA5;
      pend[1][0] = 1'b1; pdat[1][0] = 8'h07;
      pend[1][1] = 1'b1; pdat[1][1] = 8'h00;
      pend[2][0] = 1'b1; pdat[2][0] = 8'h03;
      driveInputs();
      modelReset();
      repeat (2) @(negedge clk);
      #1;
      checkResetState();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed single frames, then a two-source round-robin stream.
      repeat (60) applyStimulus(0);
      pend[0][0] = 1'b1; pdat[0][0] = 8'h11;
      pend[0][1] = 1'b1; pdat[0][1] = 8'h22;
      for (int i = 0; i < 200; i++) begin
         if (!pend[0][0]) begin pend[0][0] = 1'b1; pdat[0][0] = 8'h11; end
         if (!pend[0][1] && i < 100) begin pend[0][1] = 1'b1; pdat[0][1] = 8'h22; end
         applyStimulus(0);
      end

      // Random traffic: heavy (FIFO mostly full), sparse (idle gaps), heavy.
      repeat (400) applyStimulus(2);
      repeat (300) applyStimulus(40);
      repeat (150) applyStimulus(3);

      // Reset while instance 0 is sending data bit 3.
      pend[0][0] = 1'b1; pdat[0][0] = 8'hC3;
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         applyStimulus(0);
         if (mActive[0] && mT[0] / bdOf(0) == 4) found = 1'b1;
      end
      if (!found) begin
         total++;
         bad++;
         $error("[TB] FAIL reachDataBit3 inst0 observed=0 expected=1");
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkResetState();
      @(negedge clk);
      modelReset();
      for (int u = 0; u < 3; u++)
         for (int s = 0; s < NS; s++) pend[u][s] = 1'b0;
      pend[0][0] = 1'b1; pdat[0][0] = 8'h5A;
      driveInputs();
      #1;
      checkResetState();
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (60) applyStimulus(0);

      repeat (200) applyStimulus(3);
      repeat (300) applyStimulus(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
